// File: rtl/alu_div_unit_pkg.sv
// Shared encodings for the integer divide unit: request opcodes and FSM states.
// Also imported by the decoder and the shift/multiply units, so keep encodings stable.
package alu_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module alu_div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;

    // A set top bit means the true shifted value exceeds any N-bit divisor.
    always_comb begin
        shifted = {rem_in[N-1:0], dividend_bit};
        q_bit   = rem_in[N] | (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle integer divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one CALC cycle.
module alu_div_unit
    import alu_div_unit_pkg::*;
#(
    parameter int N = 32,
    parameter int C = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    div_state_e   state_q, state_d;
    logic [C-1:0] cnt_q, cnt_d;
    div_op_e      op_q, op_d;
    logic         neg_quo_q, neg_quo_d;
    logic         neg_rem_q, neg_rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [N:0]   rem_q, rem_d;

    logic         req_signed;
    logic         dvd_neg, dvs_neg, dvs_zero, accept;
    logic [N-1:0] dvd_mag, dvs_mag;
    logic [N:0]   step_rem;
    logic         step_q;
    logic [N-1:0] raw_res;
    logic         raw_neg;

`ifdef DIV_EARLY_OUT_EN
    logic         early_q, early_d;
    logic         req_ovf;
`endif

    always_comb begin
        req_signed = is_signed_op(div_op_e'(req_op));
        dvd_neg    = req_signed & dividend[N-1];
        dvs_neg    = req_signed & divisor[N-1];
        dvs_zero   = (divisor == '0);
        dvd_mag    = dvd_neg ? (~dividend + N'(1)) : dividend;
        dvs_mag    = dvs_neg ? (~divisor + N'(1)) : divisor;
        accept     = req_valid & req_ready & ~flush;
`ifdef DIV_EARLY_OUT_EN
        req_ovf    = req_signed & (dividend == {1'b1, {(N-1){1'b0}}}) & (divisor == '1);
`endif
    end

    alu_div_step #(.N(N)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (quo_q[N-1]),
        .divisor      (dvs_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // quo_q starts as the dividend magnitude and fills with quotient bits as it shifts out.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
`ifdef DIV_EARLY_OUT_EN
        early_d   = early_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = div_op_e'(req_op);
                    neg_quo_d = (dvd_neg ^ dvs_neg) & ~dvs_zero;
                    neg_rem_d = dvd_neg;
                    quo_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
`ifdef DIV_EARLY_OUT_EN
                    early_d   = dvs_zero | req_ovf;
`endif
                end
            end
            ST_CALC: begin
                quo_d = {quo_q[N-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + C'(1);
                if (cnt_q == C'(N-1)) begin
                    state_d = ST_DONE;
                end
`ifdef DIV_EARLY_OUT_EN
                // Overflow keeps the dividend magnitude as quotient; zero divisor returns it as remainder.
                if (early_q) begin
                    quo_d   = (dvs_q == '0) ? '1 : quo_q;
                    rem_d   = (dvs_q == '0) ? {1'b0, quo_q} : '0;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= early_d;
`endif
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        res_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        raw_res   = is_rem_op(op_q) ? rem_q[N-1:0] : quo_q;
        raw_neg   = is_rem_op(op_q) ? neg_rem_q : neg_quo_q;
        result    = '0;
        if (res_valid) begin
            result = raw_neg ? (~raw_res + N'(1)) : raw_res;
        end
    end

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed self-checking bench for alu_div_unit: arithmetic vectors, special cases,
// backpressure, flush and asynchronous reset mid-operation.
module tb_alu_div_unit;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    localparam int CALC_LAT = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    alu_div_unit #(.N(32), .C(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, " res_valid"}, {31'b0, res_valid}, 32'd0);
        checkOutput({tag, " busy"},      {31'b0, busy},      32'd0);
        checkOutput({tag, " result"},    result,             32'd0);
    endtask

    task automatic startRequest(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op    = op;
        dividend  = a;
        divisor   = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dividend  = '0;
        divisor   = '0;
    endtask

    task automatic countValids(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) seen++;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat, input string tag);
        int lat;
        startRequest(op, a, b);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput(tag, result, expRes);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput({tag, " ready after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = DIVU;
        dividend  = '0;
        divisor   = '0;
        res_ready = 1'b0;
        #2;
        checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("post reset");

        applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, CALC_LAT, "DIVU 100/7");
        applyStimulus(REMU, 32'd100, 32'd7, 32'd2,  CALC_LAT, "REMU 100/7");
        applyStimulus(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, CALC_LAT, "DIV -7/2");
        applyStimulus(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, CALC_LAT, "REM -7/2");
        applyStimulus(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, CALC_LAT, "REM 7/-2");
        applyStimulus(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, CALC_LAT, "DIV 7/-2");
        applyStimulus(DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, CALC_LAT, "DIV -7/-2");
        applyStimulus(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, CALC_LAT, "DIVU max/1");
        applyStimulus(DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, CALC_LAT, "DIVU big/2");
        applyStimulus(REMU, 32'd3, 32'd10, 32'd3, CALC_LAT, "REMU 3/10");

        applyStimulus(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, "DIV overflow");
        applyStimulus(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT, "REM overflow");
        applyStimulus(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, "DIVU 5/0");
        applyStimulus(REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, "REMU 5/0");
        applyStimulus(DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, "DIV -5/0");
        applyStimulus(REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT, "REM -5/0");

        // Backpressure: result must hold while the consumer stalls.
        startRequest(DIVU, 32'd20, 32'd4);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("hold latency", lat, CALC_LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold res_valid", {31'b0, res_valid}, 32'd1);
            checkOutput("hold result",    result,             32'd5);
            checkOutput("hold req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkIdleOutputs("hold release");

        // Flush at CALC cycle 10, then flush held against a pending request in IDLE.
        startRequest(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = DIVU;
        dividend  = 32'd50;
        divisor   = 32'd5;
        @(posedge clk);
        #1;
        checkIdleOutputs("flush calc");
        @(posedge clk);
        #1;
        checkOutput("flush beats req busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        countValids(40, seen);
        checkOutput("flush no result", seen, 32'd0);
        applyStimulus(DIVU, 32'd9, 32'd3, 32'd3, CALC_LAT, "DIVU 9/3 after flush");

        // Flush in DONE wins over res_ready and drops the result.
        startRequest(DIVU, 32'd8, 32'd2);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done flush latency", lat, CALC_LAT);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkIdleOutputs("flush done");

        // Asynchronous reset in the middle of CALC cycle 5.
        startRequest(DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("reset mid calc");
        @(negedge clk);
        rst_n = 1'b1;
        countValids(40, seen);
        checkOutput("reset no result", seen, 32'd0);
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, CALC_LAT, "DIVU after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/alu_div_unit.md
ALU_DIV_UNIT -- requirements
Module: alu_div_unit

Interface
REQ-001 Parameter N, default 32, operand/result width in bits.
REQ-002 Parameter C, default 5, iteration-counter width; SHALL satisfy 2^C >= N.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort of any operation in progress.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 dividend  input  N  rs1 operand.
REQ-010 divisor  input  N  rs2 operand.
REQ-011 res_valid  output  1  result present.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 result  output  N  quotient or remainder per req_op.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, CALC, DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept on rising edge with req_valid & req_ready; latch op, operands, operand signs; go to CALC; counter cleared.
REQ-017 CALC: restoring division of operand magnitudes, one quotient bit per cycle, MSB first; N+1-bit partial remainder.
REQ-018 CALC lasts exactly N cycles; the N-th CALC edge enters DONE, so res_valid rises N edges after the accepting edge.
REQ-019 DONE: res_valid=1, result stable; leave to IDLE on edge with res_ready=1; hold otherwise.
REQ-020 Signed ops: quotient negated when operand signs differ; remainder takes sign of dividend.
REQ-021 Divisor zero: quotient all-ones, remainder = dividend (unsigned and signed).
REQ-022 Signed overflow (dividend = -2^(N-1), divisor = -1): quotient = -2^(N-1), remainder 0.
REQ-023 result SHALL be 0 whenever res_valid=0.
REQ-024 flush=1 in any state SHALL force IDLE next edge, discard result, and take priority over req_valid and res_ready.
REQ-025 Back-to-back: a new request is acceptable in the cycle after DONE exits; no acceptance in the same cycle as res_ready handshake.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter 0, all datapath registers 0.
REQ-027 Reset values: req_ready=1, res_valid=0, busy=0, result=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL drop the operation with no result emitted.

Configuration
REQ-029 Macro DIV_EARLY_OUT_EN: when defined, divisor-zero and signed-overflow requests SHALL skip CALC and enter DONE on the edge after acceptance (res_valid after 1 edge).
REQ-030 Without DIV_EARLY_OUT_EN, those cases SHALL run the full N CALC cycles and still produce REQ-021/REQ-022 results.

Structure
REQ-031 Shared package holds op encodings (DIV/DIVU/REM/REMU) and state encoding; shared with the decoder and the shift/multiply units.
REQ-032 One sub-module alu_div_step: combinational single restoring iteration (partial remainder, divisor in; next remainder, quotient bit out).

Verification
REQ-033 DIVU 100/7 -> result 14 after exactly 32 edges; REMU 100/7 -> 2.
REQ-034 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; latency 1 with DIV_EARLY_OUT_EN, 32 without.
REQ-036 res_ready held low 10 cycles in DONE -> res_valid and result stable; req_ready=0 throughout.
REQ-037 flush at CALC cycle 10 -> IDLE next edge, no res_valid; new request DIVU 9/3 -> 3.
REQ-038 rst_n low at CALC cycle 5 -> outputs at reset values immediately, no res_valid after release.
